// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared types and constants for the register-bus transfer controller
//   BUS_W   width of the shared tri-state data bus
//   state_t transfer sequencer states
//   idx_w   index width for n items (never below 1 bit)
package bus_ctrl_pkg;
    localparam int BUS_W = 8;
    typedef enum logic [1:0] {IDLE, DRIVE, XFER, TURN} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among N level requests, pointer owned here
//   clock, n_reset  clock and asynchronous active-low reset
//   req             request vector
//   advance         commit the current pick; pointer moves past the winner
//   grant_id        index of the picked requester (valid when any)
//   any             at least one request asserted
module rr_arbiter
    import bus_ctrl_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic          clock,
    input  logic          n_reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] grant_id,
    output logic          any
);
    logic [IW-1:0] ptr;
    logic          found;

    // First asserted request scanning upward from the pointer, wrapping at N.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found    = 1'b1;
                grant_id = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign any = |req;

    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + IW'(1);
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one register-to-register move at a time on the shared bus
//   clock, n_reset   clock and asynchronous active-low reset
//   req              per-requester level request, sampled only in IDLE
//   req_src/req_dst  per-requester source/destination register index
//   gnt              one-cycle pulse when the requester's move is committed
//   err              pulses with gnt when the move was rejected as a nop
//   rd_en/wr_en      one-hot-or-zero bus drive/capture enables per register
//   busy             sequencer not in IDLE
module bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int NREQ  = 2,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic                       clock,
    input  logic                       n_reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][SEL_W-1:0] req_src,
    input  logic [NREQ-1:0][SEL_W-1:0] req_dst,
    output logic [NREQ-1:0]            gnt,
    output logic                       err,
    output logic [NREG-1:0]            rd_en,
    output logic [NREG-1:0]            wr_en,
    output logic                       busy
);
    localparam int IW = idx_w(NREQ);

    state_t           state, next_state;
    logic [IW-1:0]    win_id, win;
    logic [SEL_W-1:0] cand_src, cand_dst, src, dst;
    logic             cand_bad, bad, any, take;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clock    (clock),
        .n_reset  (n_reset),
        .req      (req),
        .advance  (take),
        .grant_id (win_id),
        .any      (any)
    );

    assign take     = (state == IDLE) && any;
    assign cand_src = req_src[win_id];
    assign cand_dst = req_dst[win_id];
    assign cand_bad = (cand_src == cand_dst) || (int'(cand_src) >= NREG) || (int'(cand_dst) >= NREG);

    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset)
            state <= IDLE;
        else
            state <= next_state;

    // Move fields are frozen at the IDLE decision so later input changes are ignored.
    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset) begin
            win <= '0;
            src <= '0;
            dst <= '0;
            bad <= 1'b0;
        end else if (take) begin
            win <= win_id;
            src <= cand_src;
            dst <= cand_dst;
            bad <= cand_bad;
        end

    always_comb begin
        next_state = (state == IDLE)  ? (any ? (cand_bad ? TURN : DRIVE) : IDLE) :
                     (state == DRIVE) ? XFER :
                     (state == XFER)  ? TURN : IDLE;
    end

    // Enables come only from registered state, so an async reset clears them at once.
    always_comb begin
        rd_en = ((state == DRIVE) || (state == XFER)) ? NREG'(1) << src : '0;
        wr_en = (state == XFER) ? NREG'(1) << dst : '0;
        err   = (state == TURN) && bad;
        gnt   = ((state == XFER) || err) ? NREQ'(1) << win : '0;
        busy  = state != IDLE;
    end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: self-checking bench with a register/bus model and a grant scoreboard
module tb_bus_xfer_ctrl;
    import bus_ctrl_pkg::*;

    localparam int NREG  = 4;
    localparam int NREQ  = 2;
    localparam int SEL_W = 2;

    typedef struct packed {
        logic id;
        logic err;
    } exp_t;

    logic                       clock = 1'b0;
    logic                       n_reset = 1'b0;
    logic [NREQ-1:0]            req = '0;
    logic [NREQ-1:0][SEL_W-1:0] req_src = '0;
    logic [NREQ-1:0][SEL_W-1:0] req_dst = '0;
    logic [NREQ-1:0]            gnt;
    logic                       err;
    logic [NREG-1:0]            rd_en, wr_en;
    logic                       busy;

    logic [BUS_W-1:0] regs [NREG];
    logic [BUS_W-1:0] pl_vals [NREG];
    logic             pl_en = 1'b0;
    logic [BUS_W-1:0] bus;
    logic             bus_drv;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   gnt_cnt = 0;
    int   en_cnt = 0;

    bus_xfer_ctrl #(.NREG(NREG), .NREQ(NREQ), .SEL_W(SEL_W)) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .req     (req),
        .req_src (req_src),
        .req_dst (req_dst),
        .gnt     (gnt),
        .err     (err),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Bus model: OR of the driving registers; bus_drv low means the bus floats.
    always_comb begin
        bus = '0;
        for (int i = 0; i < NREG; i++)
            if (rd_en[i]) bus = bus | regs[i];
    end
    assign bus_drv = |rd_en;

    always @(posedge clock) begin
        for (int i = 0; i < NREG; i++) begin
            if (pl_en) regs[i] <= pl_vals[i];
            else if (wr_en[i]) regs[i] <= bus;
        end
    end

    // Per-cycle monitor: one-hot enables, err implies gnt, grants popped from scoreboard.
    always @(negedge clock) begin
        exp_t e;
        checks++;
        if ($countones(rd_en) > 1 || $countones(wr_en) > 1) begin
            errors++;
            $display("FAIL onehot rd_en=%b wr_en=%b required at most one bit each", rd_en, wr_en);
        end
        if (rd_en != '0 || wr_en != '0) en_cnt++;
        if (gnt != '0) begin
            gnt_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt gnt=%b err=%b required no grant", gnt, err);
            end else begin
                e = sb.pop_front();
                if (gnt !== (NREQ'(1) << e.id) || err !== e.err) begin
                    errors++;
                    $display("FAIL grant gnt=%b err=%b required gnt=%b err=%b",
                             gnt, err, NREQ'(1) << e.id, e.err);
                end
            end
        end else if (err) begin
            checks++;
            errors++;
            $display("FAIL err_without_gnt err=%b gnt=%b required gnt nonzero", err, gnt);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [BUS_W-1:0] a, b, c, d);
        pl_vals[0] = a;
        pl_vals[1] = b;
        pl_vals[2] = c;
        pl_vals[3] = d;
        pl_en = 1'b1;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        req = '0;
        repeat (2) cyc();
        checks++;
        if ({rd_en, wr_en, gnt, err, busy} !== '0 || bus_drv !== 1'b0) begin
            errors++;
            $display("FAIL reset rd=%b wr=%b gnt=%b err=%b busy=%b drv=%b required all 0",
                     rd_en, wr_en, gnt, err, busy, bus_drv);
        end
        n_reset = 1'b1;
        cyc();
    endtask

    task automatic test_contention();
        int g0;
        preload(8'd11, 8'd22, 8'd33, 8'd44);
        req_src[0] = 2'd0; req_dst[0] = 2'd1;
        req_src[1] = 2'd1; req_dst[1] = 2'd3;
        sb.push_back('{id: 1'b0, err: 1'b0});
        sb.push_back('{id: 1'b1, err: 1'b0});
        sb.push_back('{id: 1'b0, err: 1'b0});
        sb.push_back('{id: 1'b1, err: 1'b0});
        g0 = gnt_cnt;
        req = 2'b11;
        repeat (16) @(posedge clock);
        #1;
        req = '0;
        cyc();
        checks++;
        if (gnt_cnt - g0 != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL contention_count grants=%0d left=%0d required 4 and 0", gnt_cnt - g0, sb.size());
        end
        checks++;
        if (regs[1] !== 8'd11 || regs[3] !== 8'd11 || busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_data r1=%0d r3=%0d busy=%b required 11 11 0", regs[1], regs[3], busy);
        end
    endtask

    task automatic test_single();
        preload(8'd20, 8'd0, 8'd0, 8'd0);
        req_src[0] = 2'd0; req_dst[0] = 2'd2;
        sb.push_back('{id: 1'b0, err: 1'b0});
        req = 2'b01;
        cyc();
        req = '0;
        checks++;
        if (rd_en !== 4'b0001 || wr_en !== 4'b0000 || gnt !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drive rd=%b wr=%b gnt=%b busy=%b required 0001 0000 00 1", rd_en, wr_en, gnt, busy);
        end
        cyc();
        checks++;
        if (rd_en !== 4'b0001 || wr_en !== 4'b0100 || gnt !== 2'b01 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_xfer rd=%b wr=%b gnt=%b err=%b required 0001 0100 01 0", rd_en, wr_en, gnt, err);
        end
        cyc();
        checks++;
        if (regs[2] !== 8'd20) begin
            errors++;
            $display("FAIL single_data r2=%0d required 20", regs[2]);
        end
        checks++;
        if (rd_en !== 4'b0000 || wr_en !== 4'b0000 || gnt !== 2'b00 || bus_drv !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_turn rd=%b wr=%b gnt=%b drv=%b busy=%b required 0000 0000 00 0 1",
                     rd_en, wr_en, gnt, bus_drv, busy);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_reject();
        int n0;
        preload(8'd1, 8'd2, 8'd3, 8'd4);
        n0 = en_cnt;
        req_src[1] = 2'd3; req_dst[1] = 2'd3;
        sb.push_back('{id: 1'b1, err: 1'b1});
        req = 2'b10;
        cyc();
        req = '0;
        checks++;
        if (gnt !== 2'b10 || err !== 1'b1 || rd_en !== 4'b0000 || wr_en !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reject_turn gnt=%b err=%b rd=%b wr=%b busy=%b required 10 1 0000 0000 1",
                     gnt, err, rd_en, wr_en, busy);
        end
        cyc();
        checks++;
        if (gnt !== 2'b00 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_idle gnt=%b err=%b busy=%b required 00 0 0", gnt, err, busy);
        end
        checks++;
        if (en_cnt != n0 || regs[0] !== 8'd1 || regs[1] !== 8'd2 || regs[2] !== 8'd3 || regs[3] !== 8'd4) begin
            errors++;
            $display("FAIL reject_quiet en_cycles=%0d regs=%0d,%0d,%0d,%0d required 0 and 1,2,3,4",
                     en_cnt - n0, regs[0], regs[1], regs[2], regs[3]);
        end
    endtask

    task automatic test_drop_req();
        int g0;
        preload(8'd0, 8'd77, 8'd0, 8'd0);
        req_src[0] = 2'd1; req_dst[0] = 2'd0;
        sb.push_back('{id: 1'b0, err: 1'b0});
        g0 = gnt_cnt;
        req = 2'b01;
        cyc();
        req = '0;
        checks++;
        if (rd_en !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_drive rd=%b busy=%b required 0010 1", rd_en, busy);
        end
        repeat (4) cyc();
        checks++;
        if (regs[0] !== 8'd77 || gnt_cnt - g0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_done r0=%0d grants=%0d busy=%b required 77 1 0", regs[0], gnt_cnt - g0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int g0;
        preload(8'd9, 8'd0, 8'd5, 8'd0);
        req_src[0] = 2'd0; req_dst[0] = 2'd2;
        g0 = gnt_cnt;
        req = 2'b01;
        cyc();
        req = '0;
        cyc();
        checks++;
        if (wr_en !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_xfer wr=%b required 0100", wr_en);
        end
        #1;
        n_reset = 1'b0;
        #1;
        checks++;
        if (rd_en !== 4'b0000 || wr_en !== 4'b0000 || gnt !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async rd=%b wr=%b gnt=%b busy=%b required 0000 0000 00 0", rd_en, wr_en, gnt, busy);
        end
        cyc();
        n_reset = 1'b1;
        cyc();
        checks++;
        if (regs[2] !== 8'd5 || gnt_cnt != g0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after r2=%0d grants=%0d busy=%b required 5 0 0", regs[2], gnt_cnt - g0, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_reject();
        test_drop_req();
        test_reset_mid();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left pending=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
